// File: rtl/stack_id_enum_pkg.sv
// Shared types and frame layout helpers for the 3D-stack die enumeration block.
// Frame fields from LSB: magic, dst_id, src_id, pwr, type.
package stack_enum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_ID,
    TX_ACK,
    TX_OFFER,
    WAIT_ACK,
    DONE
  } state_t;

  localparam logic [1:0] TYPE_OFFER = 2'b11;
  localparam logic [1:0] TYPE_ACK   = 2'b10;

  function automatic int off_dst(input int magic_w);
    return magic_w;
  endfunction

  function automatic int off_src(input int magic_w, input int id_w);
    return magic_w + id_w;
  endfunction

  function automatic int off_pwr(input int magic_w, input int id_w);
    return magic_w + 2 * id_w;
  endfunction

  function automatic int off_type(
    input int magic_w,
    input int id_w,
    input int pwr_w
  );
    return magic_w + 2 * id_w + pwr_w;
  endfunction

endpackage

// File: rtl/stack_id_enum_if.sv
// Frame link between adjacent dies: receive side plus
// valid/ready transmit side.
interface stack_id_enum_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output out_valid,
    output data_out
  );

  modport slave (
    output in_valid,
    output data_in,
    output out_ready,
    input  out_valid,
    input  data_out
  );
endinterface

// File: rtl/stack_id_enum_codec.sv
// Combinational frame packer/unpacker for the enumeration link.
// Flags magic match and offer/ack type on the received frame.
module stack_frame_codec
  import stack_enum_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 ID_W    = 5,
  parameter int                 PWR_W   = 4,
  parameter int                 MAGIC_W = 16,
  parameter logic [MAGIC_W-1:0] MAGIC   = 16'hBEAF
) (
  input  logic [1:0]        tx_type,
  input  logic [ID_W-1:0]   tx_dst,
  input  logic [ID_W-1:0]   tx_src,
  input  logic [PWR_W-1:0]  tx_pwr,
  output logic [DATA_W-1:0] tx_frame,
  input  logic [DATA_W-1:0] rx_frame,
  output logic [ID_W-1:0]   rx_dst,
  output logic [ID_W-1:0]   rx_src,
  output logic [PWR_W-1:0]  rx_pwr,
  output logic              magic_ok,
  output logic              is_offer,
  output logic              is_ack
);

  localparam int OD = off_dst(MAGIC_W);
  localparam int OS = off_src(MAGIC_W, ID_W);
  localparam int OP = off_pwr(MAGIC_W, ID_W);
  localparam int OT = off_type(MAGIC_W, ID_W, PWR_W);
  localparam int FW = OT + 2;

  logic [1:0] rx_type;

  always_comb begin
    tx_frame                = '0;
    tx_frame[MAGIC_W-1:0]   = MAGIC;
    tx_frame[OD +: ID_W]    = tx_dst;
    tx_frame[OS +: ID_W]    = tx_src;
    tx_frame[OP +: PWR_W]   = tx_pwr;
    tx_frame[OT +: 2]       = tx_type;
  end

  assign magic_ok = rx_frame[MAGIC_W-1:0] == MAGIC;
  assign rx_dst   = rx_frame[OD +: ID_W];
  assign rx_src   = rx_frame[OS +: ID_W];
  assign rx_pwr   = rx_frame[OP +: PWR_W];
  assign rx_type  = rx_frame[OT +: 2];
  assign is_offer = magic_ok && (rx_type == TYPE_OFFER);
  assign is_ack   = magic_ok && (rx_type == TYPE_ACK);

  // Upper pad bits carry no information on receive
  generate
    if (DATA_W > FW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^rx_frame[DATA_W-1:FW];
    end
  endgenerate

endmodule

// File: rtl/stack_id_enum.sv
// Die-level chip-ID enumeration controller for a 3D stack.
// Optional STACK_ENUM_BACKOFF_EN: ack window doubles per retry, capped at 16x.
module stack_id_enum
  import stack_enum_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ID_W     = 5,
  parameter int                 PWR_W    = 4,
  parameter int                 MAGIC_W  = 16,
  parameter logic [MAGIC_W-1:0] MAGIC    = 16'hBEAF,
  parameter int                 TIMEOUT  = 36,
  parameter int                 PWR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_layer,
  input  logic              start,
  stack_id_enum_if.master   link,
  output logic [ID_W-1:0]   chip_id,
  output logic [PWR_W-1:0]  power_value,
  output logic              is_top,
  output logic              sort_finish
);

`ifdef STACK_ENUM_BACKOFF_EN
  localparam int TW = 20;
`else
  localparam int TW = 16;
`endif

  localparam logic [ID_W-1:0]  ID_MAX  = {ID_W{1'b1}};
  localparam logic [PWR_W-1:0] PWR_MAX = {PWR_W{1'b1}};

  state_t            state_q, nxt_state;
  logic [ID_W-1:0]   nxt_chip_id;
  logic [PWR_W-1:0]  pwr_q, nxt_pwr;
  logic [PWR_W-1:0]  nxt_power_value;
  logic              nxt_is_top;
  logic [TW-1:0]     timer_q, nxt_timer;
  logic [TW-1:0]     win;

  logic              tx_ack, tx_en;
  logic [1:0]        tx_type;
  logic [ID_W-1:0]   tx_dst;
  logic [PWR_W-1:0]  tx_pwr;
  logic [DATA_W-1:0] tx_frame;
  logic [ID_W-1:0]   rx_dst, rx_src;
  logic [PWR_W-1:0]  rx_pwr;
  logic              magic_ok, is_offer, is_ack;
  logic              rx_offer, rx_ack, xfer;
  logic              unused_rx;

`ifdef STACK_ENUM_BACKOFF_EN
  logic [2:0] att_q, nxt_att;
  assign win = TW'(TIMEOUT) << att_q;
`else
  assign win = TW'(TIMEOUT);
`endif

  stack_frame_codec #(
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .PWR_W   (PWR_W),
    .MAGIC_W (MAGIC_W),
    .MAGIC   (MAGIC)
  ) u_codec (
    .tx_type  (tx_type),
    .tx_dst   (tx_dst),
    .tx_src   (nxt_chip_id),
    .tx_pwr   (tx_pwr),
    .tx_frame (tx_frame),
    .rx_frame (link.data_in),
    .rx_dst   (rx_dst),
    .rx_src   (rx_src),
    .rx_pwr   (rx_pwr),
    .magic_ok (magic_ok),
    .is_offer (is_offer),
    .is_ack   (is_ack)
  );

  assign unused_rx   = ^{rx_src, rx_pwr, magic_ok};
  assign rx_offer    = link.in_valid && is_offer;
  assign rx_ack      = link.in_valid && is_ack;
  assign xfer        = link.out_valid && link.out_ready;
  assign sort_finish = state_q == DONE;

  always_comb begin
    nxt_state       = state_q;
    nxt_chip_id     = chip_id;
    nxt_pwr         = pwr_q;
    nxt_power_value = power_value;
    nxt_is_top      = is_top;
    nxt_timer       = timer_q;
`ifdef STACK_ENUM_BACKOFF_EN
    nxt_att         = att_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) nxt_state = f_layer ? TX_OFFER : RX_ID;
      end
      RX_ID: begin
        if (rx_offer) begin
          nxt_chip_id = rx_dst;
          nxt_state   = TX_ACK;
        end
      end
      TX_ACK: begin
        if (xfer) nxt_state = TX_OFFER;
      end
      TX_OFFER: begin
        if (chip_id == ID_MAX) begin
          nxt_is_top = 1'b1;
          nxt_state  = DONE;
        end else if (xfer) begin
          nxt_power_value = pwr_q;
          nxt_timer       = '0;
          nxt_state       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A matching ack outranks the timeout in the same cycle
        if (rx_ack && rx_dst == chip_id) begin
          nxt_state = DONE;
        end else if (timer_q == win - TW'(1)) begin
          if (pwr_q != PWR_MAX) begin
            nxt_pwr   = pwr_q + PWR_W'(1);
            nxt_state = TX_OFFER;
`ifdef STACK_ENUM_BACKOFF_EN
            if (att_q != 3'd4) nxt_att = att_q + 3'd1;
`endif
          end else begin
            nxt_is_top = 1'b1;
            nxt_state  = DONE;
          end
        end else begin
          nxt_timer = timer_q + TW'(1);
        end
      end
      DONE: begin
        nxt_state = DONE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Frame fields follow the next state so data_out lands with entry
  always_comb begin
    tx_ack  = nxt_state == TX_ACK;
    tx_en   = tx_ack || (nxt_state == TX_OFFER && nxt_chip_id != ID_MAX);
    tx_type = tx_ack ? TYPE_ACK : TYPE_OFFER;
    tx_dst  = tx_ack ? nxt_chip_id - ID_W'(1) : nxt_chip_id + ID_W'(1);
    tx_pwr  = tx_ack ? '0 : nxt_pwr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      chip_id       <= '0;
      pwr_q         <= PWR_W'(PWR_INIT);
      power_value   <= '0;
      is_top        <= 1'b0;
      timer_q       <= '0;
      link.out_valid <= 1'b0;
      link.data_out  <= '0;
`ifdef STACK_ENUM_BACKOFF_EN
      att_q         <= '0;
`endif
    end else begin
      state_q       <= nxt_state;
      chip_id       <= nxt_chip_id;
      pwr_q         <= nxt_pwr;
      power_value   <= nxt_power_value;
      is_top        <= nxt_is_top;
      timer_q       <= nxt_timer;
      link.out_valid <= tx_en;
      if (tx_en) link.data_out <= tx_frame;
`ifdef STACK_ENUM_BACKOFF_EN
      att_q         <= nxt_att;
`endif
    end
  end

endmodule

// File: tb/tb_stack_id_enum.sv
// Randomized self-checking bench for stack_id_enum.
// Expected frames and retry windows come from a transaction-level model.
module tb_stack_id_enum;

  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 36;
  localparam int PWR_INIT = 1;
  localparam int LIMIT    = 3000;
  localparam logic [1:0] T_OFFER = 2'b11;
  localparam logic [1:0] T_ACK   = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       f_layer = 1'b0;
  logic       start = 1'b0;
  logic [4:0] chip_id;
  logic [3:0] power_value;
  logic       is_top;
  logic       sort_finish;

  int errs = 0;
  int checks = 0;

  stack_id_enum_if #(.DATA_W(DATA_W)) link ();

  stack_id_enum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_layer     (f_layer),
    .start       (start),
    .link        (link),
    .chip_id     (chip_id),
    .power_value (power_value),
    .is_top      (is_top),
    .sort_finish (sort_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(
    input logic [1:0] t, input int dst, input int src, input int pwr
  );
    logic [4:0] d;
    logic [4:0] s;
    logic [3:0] p;
    d = 5'(dst);
    s = 5'(src);
    p = 4'(pwr);
    return {t, p, s, d, 16'hBEAF};
  endfunction

  function automatic int win(input int k);
`ifdef STACK_ENUM_BACKOFF_EN
    return TIMEOUT << ((k > 4) ? 4 : k);
`else
    if (k < 0) return 0;
    return TIMEOUT;
`endif
  endfunction

  function automatic int pwr_at(input int k);
    return (PWR_INIT + k > 15) ? 15 : PWR_INIT + k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    link.in_valid = 1'b1;
    link.data_in  = f;
    step();
    link.in_valid = 1'b0;
    link.data_in  = '0;
  endtask

  task automatic do_reset();
    link.in_valid  = 1'b0;
    link.data_in   = '0;
    link.out_ready = 1'b0;
    start   = 1'b0;
    f_layer = 1'b0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Waits for a frame, stalls ready, then accepts it
  task automatic get_frame(
    input int stall, output logic [31:0] f, output int gap,
    output bit stable, output bit ok
  );
    gap = 0;
    ok = 1'b0;
    stable = 1'b1;
    f = '0;
    while (!link.out_valid && gap < LIMIT) begin
      step();
      gap++;
    end
    if (!link.out_valid) return;
    f = link.data_out;
    repeat (stall) begin
      step();
      if (link.data_out !== f || !link.out_valid) stable = 1'b0;
    end
    link.out_ready = 1'b1;
    step();
    link.out_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (link.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", link.out_valid); end
    checks++; if (link.data_out !== 32'h0) begin errs++; $display("FAIL rst_data_out got %h want 0", link.data_out); end
    checks++; if (chip_id !== 5'd0) begin errs++; $display("FAIL rst_chip_id got %0d want 0", chip_id); end
    checks++; if (power_value !== 4'd0) begin errs++; $display("FAIL rst_power got %0d want 0", power_value); end
    checks++; if (is_top !== 1'b0) begin errs++; $display("FAIL rst_is_top got %b want 0", is_top); end
    checks++; if (sort_finish !== 1'b0) begin errs++; $display("FAIL rst_finish got %b want 0", sort_finish); end
  endtask

  task automatic test_bottom();
    logic [31:0] f, exp;
    int gap;
    bit st, ok;
    do_reset();
    f_layer = 1'b1;
    start = 1'b1;
    exp = {2'b11, 4'h1, 5'd0, 5'd1, 16'hBEAF};
    get_frame(0, f, gap, st, ok);
    checks++; if (!ok) begin errs++; $display("FAIL bottom_offer got none want frame"); return; end
    checks++; if (f !== exp) begin errs++; $display("FAIL bottom_frame got %h want %h", f, exp); end
    checks++; if (chip_id !== 5'd0) begin errs++; $display("FAIL bottom_id got %0d want 0", chip_id); end
    repeat (5) step();
    send(mk(T_ACK, 0, 1, 0));
    checks++; if (sort_finish !== 1'b1) begin errs++; $display("FAIL bottom_done got %b want 1", sort_finish); end
    checks++; if (is_top !== 1'b0) begin errs++; $display("FAIL bottom_top got %b want 0", is_top); end
    checks++; if (power_value !== 4'd1) begin errs++; $display("FAIL bottom_pwr got %0d want 1", power_value); end
    repeat (3) step();
    checks++; if (sort_finish !== 1'b1 || link.out_valid !== 1'b0) begin errs++; $display("FAIL bottom_hold got fin=%b ov=%b want 1 0", sort_finish, link.out_valid); end
  endtask

  task automatic test_relay(input int id, input int stall);
    logic [31:0] f, exp;
    int gap;
    bit st, ok;
    do_reset();
    start = 1'b1;
    repeat (2) step();
    send(mk(T_ACK, id, 0, 1));
    send(mk(T_OFFER, id, 0, 1) ^ 32'h0000_8000);
    repeat (2) step();
    checks++; if (chip_id !== 5'd0 || link.out_valid !== 1'b0) begin errs++; $display("FAIL relay_noise got id=%0d ov=%b want 0 0", chip_id, link.out_valid); end
    send(mk(T_OFFER, id, id - 1, 1));
    get_frame(stall, f, gap, st, ok);
    exp = mk(T_ACK, id - 1, id, 0);
    checks++; if (!ok) begin errs++; $display("FAIL relay_ack got none want frame"); return; end
    checks++; if (f !== exp || !st) begin errs++; $display("FAIL relay_ack_frame got %h stable=%b want %h", f, st, exp); end
    checks++; if (chip_id !== 5'(id)) begin errs++; $display("FAIL relay_id got %0d want %0d", chip_id, id); end
    get_frame(stall, f, gap, st, ok);
    exp = mk(T_OFFER, id + 1, id, PWR_INIT);
    checks++; if (!ok || f !== exp || !st || gap !== 0) begin errs++; $display("FAIL relay_offer got %h gap=%0d want %h gap=0", f, gap, exp); end
    repeat ($urandom_range(0, TIMEOUT - 2)) step();
    send(mk(T_ACK, id, id + 1, 0));
    checks++; if (sort_finish !== 1'b1 || is_top !== 1'b0) begin errs++; $display("FAIL relay_done got fin=%b top=%b want 1 0", sort_finish, is_top); end
  endtask

  task automatic test_no_ack();
    logic [31:0] f, exp;
    int gap;
    bit st, ok;
    int n;
    n = 16 - PWR_INIT;
    do_reset();
    f_layer = 1'b1;
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      get_frame($urandom_range(0, 2), f, gap, st, ok);
      exp = mk(T_OFFER, 1, 0, pwr_at(k));
      checks++; if (!ok || f !== exp) begin errs++; $display("FAIL noack_frame%0d got %h want %h", k, f, exp); end
      checks++; if (power_value !== 4'(pwr_at(k))) begin errs++; $display("FAIL noack_pwr%0d got %0d want %0d", k, power_value, pwr_at(k)); end
      if (k > 0) begin
        checks++; if (gap !== win(k - 1)) begin errs++; $display("FAIL noack_gap%0d got %0d want %0d", k, gap, win(k - 1)); end
      end
      if (!ok) return;
    end
    repeat (win(n - 1) - 1) step();
    checks++; if (sort_finish !== 1'b0) begin errs++; $display("FAIL noack_early got %b want 0", sort_finish); end
    step();
    checks++; if (sort_finish !== 1'b1 || is_top !== 1'b1) begin errs++; $display("FAIL noack_top got fin=%b top=%b want 1 1", sort_finish, is_top); end
    checks++; if (power_value !== 4'd15 || link.out_valid !== 1'b0) begin errs++; $display("FAIL noack_end got pwr=%0d ov=%b want 15 0", power_value, link.out_valid); end
  endtask

  task automatic test_ignore();
    logic [31:0] f, exp;
    int gap, d1, d2, w;
    bit st, ok;
    do_reset();
    f_layer = 1'b1;
    start = 1'b1;
    get_frame(0, f, gap, st, ok);
    checks++; if (!ok) begin errs++; $display("FAIL ign_first got none want frame"); return; end
    w = win(0);
    d1 = $urandom_range(0, w / 2 - 1);
    d2 = $urandom_range(w / 2, w - 1);
    for (int t = 0; t < w; t++) begin
      link.in_valid = (t == d1) || (t == d2);
      if (t == d1) link.data_in = mk(T_ACK, $urandom_range(1, 31), 1, 0);
      else if (t == d2) link.data_in = mk(T_ACK, 0, 1, 0) ^ 32'h0000_0001;
      else link.data_in = '0;
      step();
    end
    link.in_valid = 1'b0;
    exp = mk(T_OFFER, 1, 0, pwr_at(1));
    checks++; if (link.out_valid !== 1'b1 || link.data_out !== exp || sort_finish !== 1'b0) begin errs++; $display("FAIL ign_retry got ov=%b %h fin=%b want 1 %h 0", link.out_valid, link.data_out, sort_finish, exp); end
    get_frame(0, f, gap, st, ok);
    w = win(1);
    for (int t = 0; t < w; t++) begin
      link.in_valid = (t == w - 1);
      link.data_in = (t == w - 1) ? mk(T_ACK, 0, 1, 0) : '0;
      step();
    end
    link.in_valid = 1'b0;
    checks++; if (sort_finish !== 1'b1 || is_top !== 1'b0) begin errs++; $display("FAIL ign_late_ack got fin=%b top=%b want 1 0", sort_finish, is_top); end
    checks++; if (power_value !== 4'(pwr_at(1))) begin errs++; $display("FAIL ign_pwr got %0d want %0d", power_value, pwr_at(1)); end
  endtask

  task automatic test_stall_reset();
    logic [31:0] f, exp;
    int gap;
    bit st, ok;
    do_reset();
    f_layer = 1'b1;
    start = 1'b1;
    get_frame(10, f, gap, st, ok);
    exp = mk(T_OFFER, 1, 0, PWR_INIT);
    checks++; if (!ok || f !== exp || !st) begin errs++; $display("FAIL stall_frame got %h stable=%b want %h 1", f, st, exp); end
    get_frame(0, f, gap, st, ok);
    checks++; if (gap !== win(0)) begin errs++; $display("FAIL stall_gap got %0d want %0d", gap, win(0)); end
    repeat (3) step();
    checks++; if (power_value !== 4'(pwr_at(1))) begin errs++; $display("FAIL stall_pwr got %0d want %0d", power_value, pwr_at(1)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({link.out_valid, link.data_out, chip_id, power_value, is_top, sort_finish} !== '0) begin errs++; $display("FAIL async_rst got ov=%b do=%h pwr=%0d want all 0", link.out_valid, link.data_out, power_value); end
    start = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (link.out_valid !== 1'b0 || sort_finish !== 1'b0) begin errs++; $display("FAIL rst_idle got ov=%b fin=%b want 0 0", link.out_valid, sort_finish); end
    start = 1'b1;
    get_frame(0, f, gap, st, ok);
    checks++; if (!ok || f !== exp || gap !== 1) begin errs++; $display("FAIL rst_restart got %h gap=%0d want %h gap=1", f, gap, exp); end
  endtask

  task automatic test_top_id();
    logic [31:0] f, exp;
    int gap;
    bit st, ok;
    do_reset();
    start = 1'b1;
    step();
    send(mk(T_OFFER, 31, 30, 3));
    get_frame(0, f, gap, st, ok);
    exp = mk(T_ACK, 30, 31, 0);
    checks++; if (!ok || f !== exp) begin errs++; $display("FAIL top_ack got %h want %h", f, exp); end
    checks++; if (link.out_valid !== 1'b0) begin errs++; $display("FAIL top_no_offer got %b want 0", link.out_valid); end
    step();
    checks++; if (sort_finish !== 1'b1 || is_top !== 1'b1) begin errs++; $display("FAIL top_done got fin=%b top=%b want 1 1", sort_finish, is_top); end
    checks++; if (chip_id !== 5'd31 || power_value !== 4'd0 || link.out_valid !== 1'b0) begin errs++; $display("FAIL top_outs got id=%0d pwr=%0d ov=%b want 31 0 0", chip_id, power_value, link.out_valid); end
  endtask

  initial begin
    link.in_valid  = 1'b0;
    link.data_in   = '0;
    link.out_ready = 1'b0;
    test_reset();
    test_bottom();
    test_relay(3, 0);
    test_relay(0, 2);
    repeat (3) test_relay($urandom_range(1, 30), $urandom_range(0, 4));
    test_no_ack();
    test_ignore();
    test_stall_reset();
    test_top_id();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stack_id_enum.md
Name: stack_id_enum

Overview:
Die-level enumeration controller for a 3D stack.
- Each die takes its chip ID from the die below, or uses ID 0 if it is the first layer.
- It then sends an ID-offer frame upward and ramps TSV drive power until the die above acknowledges, or the maximum power level is reached, which marks this die as top of stack.
- Successor to the fixed-width self-test FSM: widths, magic word, timeout and power range are parametrised; valid/ready handshakes and an acknowledge frame are added.

Parameters:
- DATA_W, 32, frame width; must be >= 2+PWR_W+2*ID_W+MAGIC_W.
- ID_W, 5, chip ID width.
- PWR_W, 4, power-level width.
- MAGIC_W, 16, sync word width.
- MAGIC, 16'hBEAF, sync word value.
- TIMEOUT, 36, ack wait window in cycles per attempt; 1..2^16-1.
- PWR_INIT, 1, first power level used.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_layer  in  1  die is bottom of stack; static after reset
- start  in  1  level; begin enumeration
- in_valid  in  1  data_in holds a frame this cycle
- data_in  in  DATA_W  received frame
- out_valid  out  1  data_out holds a frame
- out_ready  in  1  link accepts frame
- data_out  out  DATA_W  transmitted frame
- chip_id  out  ID_W  assigned ID
- power_value  out  PWR_W  power level of last sent offer
- is_top  out  1  no die answered at max power
- sort_finish  out  1  enumeration done (state DONE)

Behaviour:
Frame fields, LSB first:
- [MAGIC_W-1:0] = MAGIC
- next ID_W bits = dst_id
- next ID_W bits = src_id
- next PWR_W bits = pwr
- next 2 bits = type: 2'b11 offer, 2'b10 ack
- Remaining upper bits are 0 on transmit and ignored on receive.
- A frame is valid only when in_valid=1 and the magic field matches.

Reset values:
- out_valid=0, data_out=0, chip_id=0, power_value=0, is_top=0, sort_finish=0
- State = IDLE; internal power register = PWR_INIT.

State machine:
- IDLE: when start=1, go to TX_OFFER if f_layer=1 (chip_id stays 0), otherwise to RX_ID.
- RX_ID: on a valid offer frame, latch chip_id=dst_id and go to TX_ACK. Ack frames and bad-magic frames are ignored. No timeout in this state.
- TX_ACK:
  - Drive ack frame: dst=chip_id-1, src=chip_id, pwr=0.
  - Hold out_valid until out_ready; the frame is transferred on the cycle out_valid&&out_ready.
  - Then go to TX_OFFER.
- TX_OFFER:
  - If chip_id == 2^ID_W-1, go directly to DONE with is_top=1; no offer is sent.
  - Otherwise drive offer frame: dst=chip_id+1, src=chip_id, pwr=current power.
  - On transfer: power_value <= current power, clear timer, go to WAIT_ACK.
- WAIT_ACK:
  - The timer counts 0..TIMEOUT-1.
  - A valid ack with dst_id==chip_id goes to DONE. Acks with any other dst_id are ignored.
  - At timer==TIMEOUT-1 with no ack:
    - If power < 2^PWR_W-1: power+1, go to TX_OFFER.
    - Otherwise set is_top=1 and go to DONE.
  - A matching ack arriving in the timeout cycle wins: go to DONE, is_top=0.
- DONE: terminal; sort_finish=1 and all outputs hold. Only reset leaves DONE; start is ignored.

Timing and arithmetic:
- Data_out latency: registered; the frame is valid the cycle after entering a TX state.
- Each new frame is presented only after the previous one has transferred.
- All ID and power arithmetic is unsigned, width-exact; power saturates at 2^PWR_W-1 with no wrap.

Async reset mid-operation aborts any transfer and returns to reset values immediately; no partial frame is retained.

Optional Feature:
Macro STACK_ENUM_BACKOFF_EN.
- Defined: the WAIT_ACK window for attempt k (k=0 first) is TIMEOUT<<k, capped at TIMEOUT<<4. The timer widens by 4 bits.
- Undefined: every attempt uses TIMEOUT cycles.

Decomposition:
- Package stack_enum_pkg holds:
  - state enum (IDLE, RX_ID, TX_ACK, TX_OFFER, WAIT_ACK, DONE)
  - frame type constants TYPE_OFFER=2'b11, TYPE_ACK=2'b10
  - frame field offset functions
- One sub-module, stack_frame_codec (combinational):
  - packs fields into data_out and unpacks data_in;
  - flags magic_ok, is_offer, is_ack.

Test Plan:
- f_layer=1, start=1, out_ready=1, ack (dst=0) 5 cycles after offer -> data_out = {2'b11,4'h1,5'd0,5'd1,16'hBEAF}; sort_finish=1, is_top=0, power_value=1.
- f_layer=0; offer with dst=3 arrives -> chip_id=3; ack frame dst=2, src=3; then offer dst=4, src=3.
- No ack ever, defaults -> offers at pwr 1..15, each 36 cycles apart; DONE with is_top=1, power_value=15.
- Ack with dst≠chip_id, then bad-magic frame -> both ignored, timeout retry proceeds; matching ack in cycle TIMEOUT-1 -> DONE, is_top=0.
- out_ready held low 10 cycles in TX_OFFER -> data_out stable, timer not started; rst_n pulsed in WAIT_ACK -> all outputs 0 asynchronously, state IDLE.
- chip_id received = 31 (ID_W=5) -> no offer sent, is_top=1; with STACK_ENUM_BACKOFF_EN, retry windows are 36, 72, 144, 288, 576, 576 cycles.
